lsu_byte_serial: RTL and testbench

Load/store unit that sits between the core's memory stage and a byte-wide data memory, acting as the initiator side of the data-memory interface. It accepts one word/half/byte load or store per request, serialises it into single-byte memory accesses (little-endian, any alignment), and reassembles load data with sign or zero extension. It returns one response pulse per request.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_extend.sv | 22 ++
 rtl/lsu_byte_serial.sv | 199 +++++++++++++++++++
 tb/tb_lsu_byte_serial.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, FSM state type and access-size helpers for the byte-serial LSU
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD,
    DRAIN,
    DONE
  } lsu_state_t;

  // Number of byte accesses needed for a given access type.
  function automatic logic [2:0] f3_nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Unsigned variants only make sense for loads; all other unlisted codes are illegal.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return we;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// rtl/lsu_extend.sv - sign/zero extension of an assembled load word by access type
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_word
);

  // Pick the extension rule from the access type; word loads pass through untouched.
  always_comb begin
    o_word = i_word;
    case (i_funct3)
      F3_B:    o_word = {{24{i_word[7]}}, i_word[7:0]};
      F3_H:    o_word = {{16{i_word[15]}}, i_word[15:0]};
      F3_BU:   o_word = {24'd0, i_word[7:0]};
      F3_HU:   o_word = {16'd0, i_word[15:0]};
      default: o_word = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_byte_serial.sv
// rtl/lsu_byte_serial.sv - load/store unit serialising word/half/byte accesses onto a byte-wide memory
module lsu_byte_serial
  import lsu_pkg::*;
#(
  parameter int A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_funct3,
  input  logic [A_WIDTH-1:0] req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [31:0]        rsp_rdata,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic               mem_we,
  output logic               mem_re,
  output logic [7:0]         mem_wd,
  input  logic [7:0]         mem_rd
);

  lsu_state_t         r_state;
  lsu_state_t         w_state_nx;
  logic [1:0]         r_idx;
  logic [1:0]         w_idx_nx;
  logic [1:0]         w_idx_inc;
  logic [A_WIDTH-1:0] r_base;
  logic [31:0]        r_wdata;
  logic [2:0]         r_funct3;
  logic [31:0]        r_shift;
  logic [31:0]        r_rdata;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic               r_rsp_err;
  logic               r_mem_we;
  logic               r_mem_re;
  logic [A_WIDTH-1:0] r_mem_addr;
  logic [7:0]         r_mem_wd;

  logic               w_accept;
  logic [2:0]         w_n;
  logic               w_last;
  logic               w_capture;
  logic               w_finish;
  logic               w_rsp_valid_nx;
  logic               w_rsp_err_nx;
  logic               w_mem_we_nx;
  logic               w_mem_re_nx;
  logic [A_WIDTH-1:0] w_mem_addr_nx;
  logic [A_WIDTH-1:0] w_next_addr;
  logic [7:0]         w_mem_wd_nx;
  logic [31:0]        w_shift_in;
  logic [31:0]        w_aligned;
  logic [31:0]        w_extended;

  assign w_accept    = req_valid && r_req_ready;
  assign w_n         = f3_nbytes(r_funct3);
  assign w_last      = ({1'b0, r_idx} == (w_n - 3'd1));
  assign w_idx_inc   = r_idx + 2'd1;
  assign w_next_addr = r_base + A_WIDTH'(w_idx_inc);

  // Bytes arrive low-first and are shifted in from the top, so after n captures
  // the value sits in the upper n bytes and is moved down before extension.
  assign w_shift_in  = {mem_rd, r_shift[31:8]};
  assign w_aligned   = w_shift_in >> {(3'd4 - w_n), 3'b000};

  lsu_extend u_extend (
    .i_word   (w_aligned),
    .i_funct3 (r_funct3),
    .o_word   (w_extended)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next state plus the next values of every registered output.
  always_comb begin
    w_state_nx     = r_state;
    w_idx_nx       = r_idx;
    w_mem_we_nx    = 1'b0;
    w_mem_re_nx    = 1'b0;
    w_mem_addr_nx  = r_mem_addr;
    w_mem_wd_nx    = r_mem_wd;
    w_rsp_valid_nx = 1'b0;
    w_rsp_err_nx   = 1'b0;
    w_capture      = 1'b0;
    w_finish       = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        w_state_nx = IDLE;
        if (w_accept) begin
          w_idx_nx = 2'd0;
          if (f3_illegal(req_funct3, req_we)) begin
            w_state_nx     = DONE;
            w_rsp_valid_nx = 1'b1;
            w_rsp_err_nx   = 1'b1;
          end else begin
            w_mem_addr_nx = req_addr;
            if (req_we) begin
              w_state_nx  = STORE;
              w_mem_we_nx = 1'b1;
              w_mem_wd_nx = req_wdata[7:0];
            end else begin
              w_state_nx  = LOAD;
              w_mem_re_nx = 1'b1;
            end
          end
        end
      end
      STORE: begin
        if (w_last) begin
          w_state_nx     = DONE;
          w_rsp_valid_nx = 1'b1;
        end else begin
          w_idx_nx      = w_idx_inc;
          w_mem_we_nx   = 1'b1;
          w_mem_addr_nx = w_next_addr;
          w_mem_wd_nx   = r_wdata[{w_idx_inc, 3'b000} +: 8];
        end
      end
      LOAD: begin
        // mem_rd carries the byte read in the previous cycle, none yet at index 0.
        w_capture = (r_idx != 2'd0);
        if (w_last) begin
          w_state_nx = DRAIN;
        end else begin
          w_idx_nx      = w_idx_inc;
          w_mem_re_nx   = 1'b1;
          w_mem_addr_nx = w_next_addr;
        end
      end
      DRAIN: begin
        w_capture      = 1'b1;
        w_finish       = 1'b1;
        w_state_nx     = DONE;
        w_rsp_valid_nx = 1'b1;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Request latch, byte index, load assembly and the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= 2'd0;
      r_base      <= '0;
      r_wdata     <= 32'd0;
      r_funct3    <= 3'd0;
      r_shift     <= 32'd0;
      r_rdata     <= 32'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wd    <= 8'd0;
    end else begin
      r_idx <= w_idx_nx;
      if (w_accept) begin
        r_base   <= req_addr;
        r_wdata  <= req_wdata;
        r_funct3 <= req_funct3;
      end
      if (w_capture) begin
        r_shift <= w_shift_in;
      end
      if (w_finish) begin
        r_rdata <= w_extended;
      end
      r_req_ready <= (w_state_nx == IDLE) || (w_state_nx == DONE);
      r_rsp_valid <= w_rsp_valid_nx;
      r_rsp_err   <= w_rsp_err_nx;
      r_mem_we    <= w_mem_we_nx;
      r_mem_re    <= w_mem_re_nx;
      r_mem_addr  <= w_mem_addr_nx;
      r_mem_wd    <= w_mem_wd_nx;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;
  assign mem_wd    = r_mem_wd;

endmodule

// File: tb/tb_lsu_byte_serial.sv
// tb/tb_lsu_byte_serial.sv - directed and randomized bench for lsu_byte_serial against a byte-array model
module tb_lsu_byte_serial;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_wd;
  logic [7:0]  mem_rd;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem_arr [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] model_rdata;

  lsu_byte_serial #(.A_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wide synchronous memory: writes land at the edge, read data appears the next cycle.
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_addr] = mem_wd;
    if (mem_re) mem_rd <= mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 8'h00;
  end

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit is_illegal(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
  endfunction

  // Little-endian value of n bytes, then two's-complement reinterpretation for signed types.
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
    longint v;
    int     n;
    v = 0;
    n = nbytes(f3);
    for (int j = 0; j < n; j++) v = v + (longint'(ref_byte(a + 32'(j))) << (8 * j));
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered and left on a falling edge; calling it again immediately issues the
  // next request during the response cycle.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    bit          ill;
    int          n;
    int          total;
    logic [31:0] exp_rd;
    logic [31:0] wbyte;
    bit          we_e;
    bit          re_e;
    ill    = is_illegal(we, f3);
    n      = nbytes(f3);
    total  = ill ? 1 : (we ? n + 1 : n + 2);
    exp_rd = (ill || we) ? model_rdata : exp_load(f3, addr);
    chk("accept_ready", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= total; k++) begin
      if (k > 1) @(negedge clk);
      we_e = !ill && we && (k <= n);
      re_e = !ill && !we && (k <= n);
      chk("flags", {27'd0, rsp_valid, rsp_err, mem_we, mem_re, req_ready},
          {27'd0, k == total, ill && (k == total), we_e, re_e, k == total});
      if (we_e || re_e) chk("mem_addr", mem_addr, addr + 32'(k - 1));
      if (we_e) begin
        wbyte = wd >> (8 * (k - 1));
        chk("mem_wd", {24'd0, mem_wd}, {24'd0, wbyte[7:0]});
      end
    end
    chk("rsp_rdata", rsp_rdata, exp_rd);
    if (!ill && we) begin
      for (int j = 0; j < n; j++) begin
        wbyte = wd >> (8 * j);
        ref_mem[addr + 32'(j)] = wbyte[7:0];
      end
    end
    model_rdata = exp_rd;
  endtask

  task automatic idle(input int c);
    repeat (c) @(negedge clk);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] raddr;
    int          sel;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_funct3  = 3'd0;
    req_addr    = 32'd0;
    req_wdata   = 32'd0;
    mem_rd      = 8'd0;
    model_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_flags", {27'd0, req_ready, rsp_valid, rsp_err, mem_we, mem_re}, 32'b10000);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_wd", {24'd0, mem_wd}, 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    idle(1);

    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    idle(1);
    do_req(1'b0, 3'b000, 32'h10, 32'h0);
    chk("lb_value", rsp_rdata, 32'hFFFFFFEF);
    do_req(1'b0, 3'b100, 32'h10, 32'h0);
    chk("lbu_value", rsp_rdata, 32'h000000EF);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_value", rsp_rdata, 32'hDEADBEEF);
    do_req(1'b0, 3'b001, 32'h11, 32'h0);
    chk("lh_value", rsp_rdata, 32'hFFFFADBE);
    do_req(1'b0, 3'b101, 32'h11, 32'h0);
    chk("lhu_value", rsp_rdata, 32'h0000ADBE);
    idle(2);

    do_req(1'b1, 3'b001, 32'hFFFFFFFF, 32'h00001234);
    chk("wrap_hi", {24'd0, mem_byte(32'hFFFFFFFF)}, 32'h34);
    chk("wrap_lo", {24'd0, mem_byte(32'h00000000)}, 32'h12);
    do_req(1'b0, 3'b101, 32'hFFFFFFFF, 32'h0);

    do_req(1'b0, 3'b011, 32'h10, 32'h0);
    do_req(1'b1, 3'b100, 32'h10, 32'h0);
    do_req(1'b1, 3'b000, 32'h20, 32'h000000A5);
    do_req(1'b0, 3'b000, 32'h20, 32'h0);
    chk("b2b_lb", rsp_rdata, 32'hFFFFFFA5);

    do_req(1'b1, 3'b010, 32'h10, 32'h00000000);
    idle(1);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    req_wdata  = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_c1_we", {31'd0, mem_we}, 32'd1);
    chk("abort_c1_addr", mem_addr, 32'h10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_flags", {27'd0, req_ready, rsp_valid, rsp_err, mem_we, mem_re}, 32'b10000);
    chk("abort_addr", mem_addr, 32'd0);
    chk("abort_wd", {24'd0, mem_wd}, 32'd0);
    chk("abort_rdata", rsp_rdata, 32'd0);
    model_rdata   = 32'd0;
    ref_mem[32'h10] = 8'hEF;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    chk("abort_byte0", {24'd0, mem_byte(32'h10)}, 32'hEF);
    chk("abort_byte1", {24'd0, mem_byte(32'h11)}, 32'h00);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    chk("abort_lw", rsp_rdata, 32'h000000EF);

    for (int it = 0; it < 80; it++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1:    rf3 = 3'b000;
        2, 3:    rf3 = 3'b001;
        4, 5:    rf3 = 3'b010;
        6:       rf3 = 3'b100;
        7:       rf3 = 3'b101;
        8:       rf3 = 3'b011;
        default: rf3 = ($urandom_range(0, 1) == 0) ? 3'b110 : 3'b111;
      endcase
      if ($urandom_range(0, 3) == 0) raddr = 32'hFFFFFFFC + 32'($urandom_range(0, 7));
      else raddr = 32'h100 + 32'($urandom_range(0, 15));
      do_req(1'($urandom_range(0, 1)), rf3, raddr, $urandom);
      if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
